// File: rtl/accel_pkg.sv
// Shared types and defaults for the unit dispatch arbiter.
// Provides unit FSM states, the command packet and dispatch defaults.
package accel_pkg;

  localparam int UNIT_COUNT       = 4;
  localparam int DISPATCH_CMD_W   = 8;
  localparam int DISPATCH_TIMEOUT = 1023;

  typedef struct packed {
    logic [DISPATCH_CMD_W-1:0] ctrl;
  } ctrl_packet_t;

  typedef enum logic [1:0] {
    U_FREE  = 2'd0,
    U_ISSUE = 2'd1,
    U_BUSY  = 2'd2
  } unit_state_e;

endpackage

// File: rtl/unit_dispatch_arbiter_if.sv
// Bundle between host command queues, the arbiter and the units.
// slave: arbiter side; master: host/unit side.
interface unit_dispatch_arbiter_if
  import accel_pkg::*;
#(
  parameter int REQ_COUNT  = 4,
  parameter int UNIT_COUNT = accel_pkg::UNIT_COUNT,
  parameter int CMD_W      = DISPATCH_CMD_W
);

  localparam int OW = $clog2(REQ_COUNT);
  localparam int BW = $clog2(UNIT_COUNT) + 1;

  logic                             enable;
  logic [REQ_COUNT-1:0]             req_valid;
  logic [REQ_COUNT-1:0][CMD_W-1:0]  req_cmd;
  logic [REQ_COUNT-1:0]             req_ready;
  logic [UNIT_COUNT-1:0]            unit_ready;
  logic [UNIT_COUNT-1:0]            unit_done;
  logic [UNIT_COUNT-1:0]            unit_cmd_vld;
  logic [UNIT_COUNT-1:0][CMD_W-1:0] unit_cmd;
  logic [UNIT_COUNT-1:0][OW-1:0]    unit_owner;
  logic [UNIT_COUNT-1:0]            cmpl_valid;
  logic [UNIT_COUNT-1:0]            timeout_err;
  logic                             err_clear;
  logic [BW-1:0]                    busy_count;

  modport slave (
    input  enable, req_valid, req_cmd,
    input  unit_ready, unit_done, err_clear,
    output req_ready, unit_cmd_vld, unit_cmd,
    output unit_owner, cmpl_valid, timeout_err,
    output busy_count
  );

  modport master (
    output enable, req_valid, req_cmd,
    output unit_ready, unit_done, err_clear,
    input  req_ready, unit_cmd_vld, unit_cmd,
    input  unit_owner, cmpl_valid, timeout_err,
    input  busy_count
  );

endinterface

// File: rtl/unit_dispatch_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant from a request vector.
// Ports: clk, rst, req, advance (pointer moves past winner), gnt.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int W = $clog2(N);

  logic [W-1:0] ptr;
  logic [W-1:0] gidx;
  logic [W-1:0] idx;
  logic         found;

  // N is a power of two, so the index wraps by truncation.
  always_comb begin
    gnt   = '0;
    gidx  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (!found && req[idx]) begin
        found     = 1'b1;
        gnt[idx]  = 1'b1;
        gidx      = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= gidx + W'(1);
    end
  end

endmodule

// File: rtl/unit_dispatch_arbiter.sv
// Round-robin dispatch of requester commands onto free units.
// Ports: clk, rst, bus (commands in, unit strobes/ownership/status out).
module unit_dispatch_arbiter
  import accel_pkg::*;
#(
  parameter int REQ_COUNT      = 4,
  parameter int UNIT_COUNT     = accel_pkg::UNIT_COUNT,
  parameter int CMD_W          = DISPATCH_CMD_W,
  parameter int TIMEOUT_CYCLES = DISPATCH_TIMEOUT
) (
  input logic                   clk,
  input logic                   rst,
  unit_dispatch_arbiter_if.slave bus
);

  localparam int OW = $clog2(REQ_COUNT);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(UNIT_COUNT) + 1;

  logic [UNIT_COUNT-1:0] elig;
  logic [UNIT_COUNT-1:0] target;
  logic [UNIT_COUNT-1:0] live_d;
  logic [REQ_COUNT-1:0]  arb_req;
  logic [REQ_COUNT-1:0]  gnt;
  logic [OW-1:0]         gsel;
  logic [CMD_W-1:0]      gcmd;
  logic                  xfer;
  logic [BW-1:0]         busy_d;
  logic [BW-1:0]         busy_q;

  assign arb_req = bus.req_valid
                 & {REQ_COUNT{bus.enable & (|elig) & ~rst}};
  assign xfer = |gnt;
  assign bus.req_ready = gnt;

  rr_arbiter #(.N(REQ_COUNT)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (xfer),
    .gnt     (gnt)
  );

  always_comb begin
    gsel = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (gnt[i]) gsel = OW'(i);
    end
  end

  assign gcmd = bus.req_cmd[gsel];

  // Lowest set bit of the eligible vector.
  assign target = elig & (~elig + UNIT_COUNT'(1));

  for (genvar u = 0; u < UNIT_COUNT; u++) begin : g_unit
    unit_state_e      st_q;
    unit_state_e      st_d;
    logic [TW-1:0]    tmr_q;
    logic [CMD_W-1:0] cmd_q;
    logic [OW-1:0]    own_q;
    logic             cmpl_q;
    logic             err_q;
    logic             freed_q;
    logic             take;
    logic             done_hit;
    logic             tmo_hit;

    assign take     = xfer & target[u];
    assign done_hit = (st_q == U_BUSY) & bus.unit_done[u];
    // Done on the timeout cycle counts as a normal completion.
    assign tmo_hit  = (st_q == U_BUSY) & ~bus.unit_done[u]
                    & (tmr_q == TW'(TIMEOUT_CYCLES));

    always_comb begin
      st_d = st_q;
      unique case (st_q)
        U_FREE:  if (take) st_d = U_ISSUE;
        U_ISSUE: st_d = U_BUSY;
        U_BUSY:  if (done_hit | tmo_hit) st_d = U_FREE;
        default: st_d = U_FREE;
      endcase
    end

    // tmr_q holds the count of BUSY cycles including the current one.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q    <= U_FREE;
        tmr_q   <= '0;
        cmd_q   <= '0;
        own_q   <= '0;
        cmpl_q  <= 1'b0;
        err_q   <= 1'b0;
        freed_q <= 1'b0;
      end else begin
        st_q    <= st_d;
        cmpl_q  <= done_hit;
        freed_q <= done_hit | tmo_hit;
        err_q   <= tmo_hit | (err_q & ~bus.err_clear);
        if (st_q == U_ISSUE) begin
          tmr_q <= TW'(1);
        end else if (st_q == U_BUSY) begin
          tmr_q <= tmr_q + TW'(1);
        end else begin
          tmr_q <= '0;
        end
        if (take) begin
          cmd_q <= gcmd;
          own_q <= gsel;
        end
      end
    end

    // A just-freed unit sits out one cycle before it can be regranted.
    assign elig[u] = (st_q == U_FREE) & ~freed_q
                   & bus.unit_ready[u];
    assign live_d[u] = (st_d != U_FREE);

    assign bus.unit_cmd_vld[u] = (st_q == U_ISSUE);
    assign bus.unit_cmd[u]     = cmd_q;
    assign bus.unit_owner[u]   = own_q;
    assign bus.cmpl_valid[u]   = cmpl_q;
    assign bus.timeout_err[u]  = err_q;
  end

  always_comb begin
    busy_d = '0;
    for (int i = 0; i < UNIT_COUNT; i++) begin
      busy_d = busy_d + BW'(live_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.busy_count = busy_q;

endmodule
